// File: rtl/tts_pkg.sv
// Shared types and limits for the truth-table sweeper and its result checker.
package tts_pkg;

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} tts_state_t;

   localparam int MAX_N_IN = 8;
   localparam int MAX_N_CH = 8;
   localparam int MAX_HOLD = 15;

   // Highest input vector of an n_in-input truth table.
   function automatic logic [MAX_N_IN-1:0] last_vec(input int n_in);
      return MAX_N_IN'((1 << n_in) - 1);
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, stimulus and result bundle between the sweeper and the lab/self-test wrapper.
interface truth_table_sweeper_if #(
   parameter int N_IN = 4,
   parameter int N_CH = 1
);
   logic            start;
   logic [N_IN-1:0] stim;
   logic [N_CH-1:0] dut_y;
   logic [N_CH-1:0] ref_y;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_CH-1:0] fail_mask;
   logic [N_IN-1:0] first_fail_vec;
   logic            first_fail_valid;

   modport master (
      input  start, dut_y, ref_y,
      output stim, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_valid
   );

   modport slave (
      output start, dut_y, ref_y,
      input  stim, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/tts_checker.sv
// Accumulates per-vector mismatch results: error count, sticky channel mask, first failing vector.
import tts_pkg::*;

module tts_checker #(
   parameter int N_IN = 4,
   parameter int N_CH = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_sample,
   input  logic [N_IN-1:0] i_stim,
   input  logic [N_CH-1:0] i_dut_y,
   input  logic [N_CH-1:0] i_ref_y,
   output logic [N_IN:0]   o_err_count,
   output logic [N_CH-1:0] o_fail_mask,
   output logic [N_IN-1:0] o_first_fail_vec,
   output logic            o_first_fail_valid,
   output logic            o_hit
);
   logic [N_CH-1:0] w_mm;
   logic [N_IN:0]   r_err_count;
   logic [N_CH-1:0] r_fail_mask;
   logic [N_IN-1:0] r_first_fail_vec;
   logic            r_first_fail_valid;

   assign w_mm  = i_dut_y ^ i_ref_y;
   assign o_hit = |w_mm;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_count        <= '0;
         r_fail_mask        <= '0;
         r_first_fail_vec   <= '0;
         r_first_fail_valid <= 1'b0;
      end else if (i_clear) begin
         r_err_count        <= '0;
         r_fail_mask        <= '0;
         r_first_fail_vec   <= '0;
         r_first_fail_valid <= 1'b0;
      end else if (i_sample && o_hit) begin
         // Width N_IN+1 holds a full-table failure count without wrapping.
         r_err_count <= r_err_count + {{N_IN{1'b0}}, 1'b1};
         r_fail_mask <= r_fail_mask | w_mm;
         if (!r_first_fail_valid) begin
            r_first_fail_vec   <= i_stim;
            r_first_fail_valid <= 1'b1;
         end
      end
   end

   assign o_err_count        = r_err_count;
   assign o_fail_mask        = r_fail_mask;
   assign o_first_fail_vec   = r_first_fail_vec;
   assign o_first_fail_valid = r_first_fail_valid;
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational UUT in order and scores it against a golden model.
import tts_pkg::*;

module truth_table_sweeper #(
   parameter int N_IN = 4,
   parameter int N_CH = 1,
   parameter int HOLD = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   truth_table_sweeper_if.master bus
);
   localparam logic [1:0]          ST_IDLE  = S_IDLE;
   localparam logic [1:0]          ST_APPLY = S_APPLY;
   localparam logic [1:0]          ST_CHECK = S_CHECK;
   localparam logic [1:0]          ST_DONE  = S_DONE;
   localparam logic [MAX_N_IN-1:0] LAST_W   = last_vec(N_IN);
   localparam logic [N_IN-1:0]     LAST     = LAST_W[N_IN-1:0];
   localparam logic [3:0]          HOLD_END = 4'(HOLD - 1);

   logic [1:0]      r_state;
   logic [N_IN-1:0] r_stim;
   logic [3:0]      r_hold;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic            w_accept;
   logic            w_sample;
   logic            w_hit;

   // start only counts when no sweep is running.
   assign w_accept = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_sample = (r_state == ST_CHECK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_stim  <= '0;
         r_hold  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_state <= ST_APPLY;
                  r_stim  <= '0;
                  r_hold  <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            ST_APPLY: begin
               if (r_hold == HOLD_END) r_state <= ST_CHECK;
               else                    r_hold  <= r_hold + 4'd1;
            end
            ST_CHECK: begin
               if (r_stim == LAST) begin
                  // Fold in the last vector's result, which the checker has not registered yet.
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (bus.err_count == '0) && !w_hit;
               end else begin
                  r_stim  <= r_stim + {{(N_IN-1){1'b0}}, 1'b1};
                  r_hold  <= '0;
                  r_state <= ST_APPLY;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   tts_checker #(.N_IN(N_IN), .N_CH(N_CH)) u_chk (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_clear            (w_accept),
      .i_sample           (w_sample),
      .i_stim             (r_stim),
      .i_dut_y            (bus.dut_y),
      .i_ref_y            (bus.ref_y),
      .o_err_count        (bus.err_count),
      .o_fail_mask        (bus.fail_mask),
      .o_first_fail_vec   (bus.first_fail_vec),
      .o_first_fail_valid (bus.first_fail_valid),
      .o_hit              (w_hit)
   );

   assign bus.stim = r_stim;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.pass = r_pass;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: four sweeper configurations around a majority-gate UUT with injectable reference faults.
module tb_truth_table_sweeper;
   typedef struct {
      int         err;
      logic [7:0] mask;
      logic [7:0] ffv;
      logic       ffvalid;
      logic       pass;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;
   int   mode [4];
   exp_t sb [$];

   truth_table_sweeper_if #(.N_IN(3), .N_CH(1)) b0 ();
   truth_table_sweeper_if #(.N_IN(3), .N_CH(2)) b1 ();
   truth_table_sweeper_if #(.N_IN(4), .N_CH(1)) b2 ();
   truth_table_sweeper_if #(.N_IN(3), .N_CH(1)) b3 ();

   truth_table_sweeper #(.N_IN(3), .N_CH(1), .HOLD(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
   truth_table_sweeper #(.N_IN(3), .N_CH(2), .HOLD(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
   truth_table_sweeper #(.N_IN(4), .N_CH(1), .HOLD(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.master));
   truth_table_sweeper #(.N_IN(3), .N_CH(1), .HOLD(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.master));

   function automatic logic maj(input logic [2:0] v);
      return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
   endfunction

   // Reference-side fault pattern: 0 clean, 1 ch1 at vec 5, 2 all channels always, 3 ch0 at vec 2.
   function automatic logic [7:0] flip(input int md, input logic [7:0] v);
      case (md)
         1:       return (v == 8'd5) ? 8'h02 : 8'h00;
         2:       return 8'hFF;
         3:       return (v == 8'd2) ? 8'h01 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   function automatic exp_t model(input int nin, input int nch, input int md);
      exp_t       e;
      logic [7:0] cm;
      logic [7:0] mm;
      cm = 8'((1 << nch) - 1);
      e.err = 0; e.mask = '0; e.ffv = '0; e.ffvalid = 1'b0;
      for (int v = 0; v < (1 << nin); v++) begin
         mm = flip(md, 8'(v)) & cm;
         if (mm != 8'h00) begin
            e.err++;
            e.mask |= mm;
            if (!e.ffvalid) begin
               e.ffv     = 8'(v);
               e.ffvalid = 1'b1;
            end
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   logic [7:0] f0, f1, f2, f3;
   assign f0 = flip(mode[0], 8'(b0.stim));
   assign f1 = flip(mode[1], 8'(b1.stim));
   assign f2 = flip(mode[2], 8'(b2.stim));
   assign f3 = flip(mode[3], 8'(b3.stim));
   assign b0.dut_y = maj(b0.stim[2:0]);
   assign b1.dut_y = {2{maj(b1.stim[2:0])}};
   assign b2.dut_y = maj(b2.stim[2:0]);
   assign b3.dut_y = maj(b3.stim[2:0]);
   assign b0.ref_y = b0.dut_y ^ f0[0:0];
   assign b1.ref_y = b1.dut_y ^ f1[1:0];
   assign b2.ref_y = b2.dut_y ^ f2[0:0];
   assign b3.ref_y = b3.dut_y ^ f3[0:0];

   logic [7:0] t_stim [4];
   logic [7:0] t_mask [4];
   logic [7:0] t_ffv  [4];
   logic [8:0] t_err  [4];
   logic       t_busy [4];
   logic       t_done [4];
   logic       t_pass [4];
   logic       t_ffvl [4];

   assign t_stim[0] = 8'(b0.stim);  assign t_stim[1] = 8'(b1.stim);
   assign t_stim[2] = 8'(b2.stim);  assign t_stim[3] = 8'(b3.stim);
   assign t_mask[0] = 8'(b0.fail_mask);  assign t_mask[1] = 8'(b1.fail_mask);
   assign t_mask[2] = 8'(b2.fail_mask);  assign t_mask[3] = 8'(b3.fail_mask);
   assign t_ffv[0] = 8'(b0.first_fail_vec);  assign t_ffv[1] = 8'(b1.first_fail_vec);
   assign t_ffv[2] = 8'(b2.first_fail_vec);  assign t_ffv[3] = 8'(b3.first_fail_vec);
   assign t_err[0] = 9'(b0.err_count);  assign t_err[1] = 9'(b1.err_count);
   assign t_err[2] = 9'(b2.err_count);  assign t_err[3] = 9'(b3.err_count);
   assign t_busy[0] = b0.busy;  assign t_busy[1] = b1.busy;
   assign t_busy[2] = b2.busy;  assign t_busy[3] = b3.busy;
   assign t_done[0] = b0.done;  assign t_done[1] = b1.done;
   assign t_done[2] = b2.done;  assign t_done[3] = b3.done;
   assign t_pass[0] = b0.pass;  assign t_pass[1] = b1.pass;
   assign t_pass[2] = b2.pass;  assign t_pass[3] = b3.pass;
   assign t_ffvl[0] = b0.first_fail_valid;  assign t_ffvl[1] = b1.first_fail_valid;
   assign t_ffvl[2] = b2.first_fail_valid;  assign t_ffvl[3] = b3.first_fail_valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       b0.start = v;
         1:       b1.start = v;
         2:       b2.start = v;
         default: b3.start = v;
      endcase
   endtask

   task automatic chk_zero(input int sel);
      chk("rst_stim", 32'(t_stim[sel]), 0);
      chk("rst_busy", 32'(t_busy[sel]), 0);
      chk("rst_done", 32'(t_done[sel]), 0);
      chk("rst_pass", 32'(t_pass[sel]), 0);
      chk("rst_err",  32'(t_err[sel]),  0);
      chk("rst_mask", 32'(t_mask[sel]), 0);
      chk("rst_ffv",  32'(t_ffv[sel]),  0);
      chk("rst_ffvl", 32'(t_ffvl[sel]), 0);
   endtask

   task automatic run_sweep(input int sel, input int nin, input int nch, input int hold,
                            input int md, input bit pulse);
      int   tot;
      int   j;
      bit   seq_ok;
      exp_t e;
      tot       = (1 << nin) * (hold + 1);
      mode[sel] = md;
      sb.push_back(model(nin, nch, md));
      @(negedge clk); set_start(sel, 1'b1);
      @(posedge clk);
      @(negedge clk); set_start(sel, 1'b0);
      chk("clr_err",  32'(t_err[sel]),  0);
      chk("clr_mask", 32'(t_mask[sel]), 0);
      chk("clr_ffvl", 32'(t_ffvl[sel]), 0);
      chk("clr_done", 32'(t_done[sel]), 0);
      chk("acc_busy", 32'(t_busy[sel]), 1);
      j = 0; seq_ok = 1'b1;
      while (!t_done[sel] && j <= tot + 4) begin
         if (t_stim[sel] !== 8'(j / (hold + 1)) || t_busy[sel] !== 1'b1) seq_ok = 1'b0;
         if (pulse) set_start(sel, (j % 5 == 2) && (j < tot - 2));
         @(negedge clk);
         j++;
      end
      set_start(sel, 1'b0);
      chk("stim_seq", 32'(seq_ok), 1);
      chk("done_lat", 32'(j), 32'(tot));
      e = sb.pop_front();
      chk("err_count",   32'(t_err[sel]),  32'(e.err));
      chk("fail_mask",   32'(t_mask[sel]), 32'(e.mask));
      chk("first_vec",   32'(t_ffv[sel]),  32'(e.ffv));
      chk("first_valid", 32'(t_ffvl[sel]), 32'(e.ffvalid));
      chk("pass",        32'(t_pass[sel]), 32'(e.pass));
      chk("end_busy",    32'(t_busy[sel]), 0);
      chk("end_stim",    32'(t_stim[sel]), 32'((1 << nin) - 1));
   endtask

   initial begin
      int k;
      n_total = 0; n_bad = 0;
      for (int i = 0; i < 4; i++) mode[i] = 0;
      rst_n = 1'b0;
      b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0; b3.start = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) chk_zero(i);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep(0, 3, 1, 1, 0, 1'b0);   // clean majority
      run_sweep(1, 3, 2, 1, 1, 1'b0);   // ch1 fault at vector 5
      run_sweep(2, 4, 1, 1, 2, 1'b0);   // every vector fails: count 16
      run_sweep(3, 3, 1, 3, 0, 1'b1);   // HOLD=3 with start pulses while busy

      // Asynchronous reset in the middle of a sweep.
      mode[0] = 0;
      @(negedge clk); set_start(0, 1'b1);
      @(negedge clk); set_start(0, 1'b0);
      k = 0;
      while (t_stim[0] != 8'd3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("reach_stim3", 32'(t_stim[0]), 3);
      #2 rst_n = 1'b0;
      #1 chk_zero(0);
      @(negedge clk); rst_n = 1'b1;
      run_sweep(0, 3, 1, 1, 0, 1'b0);

      // Back-to-back: failing sweep then restart from DONE.
      run_sweep(0, 3, 1, 1, 3, 1'b0);
      run_sweep(0, 3, 1, 1, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
